// File: rtl/ps2_mouse_pkg.sv
// Shared constants and payload types for the PS/2 mouse packet decoder.
package ps2_mouse_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_B0 = 2'd0;  // await header
    localparam state_t ST_B1 = 2'd1;  // await X delta
    localparam state_t ST_B2 = 2'd2;  // await Y delta

    localparam logic [7:0] ACK_BYTE = 8'hFA;
    localparam logic [7:0] BAT_BYTE = 8'hAA;

    localparam int unsigned HDR_LBTN    = 0;
    localparam int unsigned HDR_RBTN    = 1;
    localparam int unsigned HDR_ALWAYS1 = 3;
    localparam int unsigned HDR_XSIGN   = 4;
    localparam int unsigned HDR_YSIGN   = 5;
    localparam int unsigned HDR_XOVF    = 6;
    localparam int unsigned HDR_YOVF    = 7;

    // Header bits that decoding actually needs
    typedef struct packed {
        logic yovf;
        logic xovf;
        logic ysign;
        logic xsign;
        logic rbtn;
        logic lbtn;
    } hdr_t;

    // Decoded motion presented to the object mover
    typedef struct packed {
        logic [9:0] vx;
        logic [9:0] vy;
        logic       dx;
        logic       dy;
        logic       lbtn;
        logic       rbtn;
    } motion_t;

endpackage

// File: rtl/mouse_delta_conv.sv
// Converts one 9-bit two's-complement PS/2 delta into a scaled, clamped speed and raw direction.
module mouse_delta_conv #(
    parameter int unsigned SHIFT     = 0,
    parameter int unsigned MAX_SPEED = 64
) (
    input  logic       sign_i,
    input  logic [7:0] data_i,
    input  logic       ovf_i,
    output logic [9:0] mag_o,
    output logic       dir_o
);

    localparam logic [9:0] MAX_MAG = 10'(MAX_SPEED);

    logic [9:0] value;
    logic [9:0] abs_val;
    logic [9:0] shifted;

    // Sign-extend, take magnitude (up to 256), scale down, then clamp
    always_comb begin
        value   = {sign_i, sign_i, data_i};
        abs_val = sign_i ? 10'(~value + 10'd1) : value;
        shifted = abs_val >> SHIFT;
        if (ovf_i) begin
            mag_o = MAX_MAG;
        end else if (shifted > MAX_MAG) begin
            mag_o = MAX_MAG;
        end else begin
            mag_o = shifted;
        end
    end

    assign dir_o = sign_i;

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// Assembles 3-byte PS/2 stream packets and decodes them into speed/direction/buttons.
module ps2_mouse_packet_decoder
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned SHIFT          = 0,
    parameter int unsigned MAX_SPEED      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned HOLD_CYCLES    = 5000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic [9:0] vx,
    output logic [9:0] vy,
    output logic       dx,
    output logic       dy,
    output logic       mousepush,
    output logic       right_btn,
    output logic       mouseReady,
    output logic       pkt_err
);

    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    state_t              state_q, state_d;
    logic                synced_q, synced_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    hdr_t                hdr_q, hdr_d;
    logic [7:0]          x_q, x_d;
    motion_t             mot_q, mot_d;
    logic                ready_q, ready_d;
    logic                perr_q, perr_d;

    logic [9:0]          mag_x, mag_y;
    logic                dir_x, dir_y;

    mouse_delta_conv #(.SHIFT(SHIFT), .MAX_SPEED(MAX_SPEED)) u_conv_x (
        .sign_i (hdr_q.xsign),
        .data_i (x_q),
        .ovf_i  (hdr_q.xovf),
        .mag_o  (mag_x),
        .dir_o  (dir_x)
    );

    // Y byte is decoded in the cycle it arrives, straight from rx_data
    mouse_delta_conv #(.SHIFT(SHIFT), .MAX_SPEED(MAX_SPEED)) u_conv_y (
        .sign_i (hdr_q.ysign),
        .data_i (rx_data),
        .ovf_i  (hdr_q.yovf),
        .mag_o  (mag_y),
        .dir_o  (dir_y)
    );

    // Next-state: packet framing, resync, timeout, decode and hold-off clearing
    always_comb begin
        state_d    = state_q;
        synced_d   = synced_q;
        to_cnt_d   = to_cnt_q;
        hold_cnt_d = hold_cnt_q;
        hdr_d      = hdr_q;
        x_d        = x_q;
        mot_d      = mot_q;
        ready_d    = 1'b0;
        perr_d     = 1'b0;

        if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else begin
            mot_d.vx = '0;
            mot_d.vy = '0;
            mot_d.dx = 1'b0;
            mot_d.dy = 1'b0;
        end

        if (rx_err) begin
            state_d  = ST_B0;
            to_cnt_d = '0;
            perr_d   = (state_q != ST_B0);
        end else if (rx_valid) begin
            to_cnt_d = '0;
            case (state_q)
                ST_B0: begin
                    if (!synced_q && (rx_data == ACK_BYTE || rx_data == BAT_BYTE)) begin
                        state_d = ST_B0;
                    end else if (rx_data[HDR_ALWAYS1]) begin
                        hdr_d.lbtn  = rx_data[HDR_LBTN];
                        hdr_d.rbtn  = rx_data[HDR_RBTN];
                        hdr_d.xsign = rx_data[HDR_XSIGN];
                        hdr_d.ysign = rx_data[HDR_YSIGN];
                        hdr_d.xovf  = rx_data[HDR_XOVF];
                        hdr_d.yovf  = rx_data[HDR_YOVF];
                        state_d     = ST_B1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
                ST_B1: begin
                    x_d     = rx_data;
                    state_d = ST_B2;
                end
                ST_B2: begin
                    mot_d.vx   = mag_x;
                    mot_d.vy   = mag_y;
                    mot_d.dx   = dir_x & (|mag_x);
                    mot_d.dy   = ~dir_y & (|mag_y);
                    mot_d.lbtn = hdr_q.lbtn;
                    mot_d.rbtn = hdr_q.rbtn;
                    ready_d    = 1'b1;
                    hold_cnt_d = '0;
                    synced_d   = 1'b1;
                    state_d    = ST_B0;
                end
                default: begin
                    state_d = ST_B0;
                end
            endcase
        end else if (state_q != ST_B0) begin
            if (to_cnt_q == TO_LAST) begin
                state_d  = ST_B0;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_B0;
            synced_q   <= 1'b0;
            to_cnt_q   <= '0;
            hold_cnt_q <= '0;
            hdr_q      <= '0;
            x_q        <= '0;
            mot_q      <= '0;
            ready_q    <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            synced_q   <= synced_d;
            to_cnt_q   <= to_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            hdr_q      <= hdr_d;
            x_q        <= x_d;
            mot_q      <= mot_d;
            ready_q    <= ready_d;
            perr_q     <= perr_d;
        end
    end

    assign vx         = mot_q.vx;
    assign vy         = mot_q.vy;
    assign dx         = mot_q.dx;
    assign dy         = mot_q.dy;
    assign mousepush  = mot_q.lbtn;
    assign right_btn  = mot_q.rbtn;
    assign mouseReady = ready_q;
    assign pkt_err    = perr_q;

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Scoreboard bench: two decoders (SHIFT=0 and SHIFT=2) with short timeout/hold windows.
module tb_ps2_mouse_packet_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       a_valid, a_err, b_valid, b_err;
    logic [7:0] a_data, b_data;

    logic [9:0] a_vx, a_vy, b_vx, b_vy;
    logic       a_dx, a_dy, a_mp, a_rb, a_mr, a_pe;
    logic       b_dx, b_dy, b_mp, b_rb, b_mr, b_pe;

    ps2_mouse_packet_decoder #(
        .SHIFT(0), .MAX_SPEED(64), .TIMEOUT_CYCLES(100), .HOLD_CYCLES(50)
    ) dut_a (
        .clk(clk), .rstn(rstn), .rx_valid(a_valid), .rx_data(a_data), .rx_err(a_err),
        .vx(a_vx), .vy(a_vy), .dx(a_dx), .dy(a_dy), .mousepush(a_mp), .right_btn(a_rb),
        .mouseReady(a_mr), .pkt_err(a_pe)
    );

    ps2_mouse_packet_decoder #(
        .SHIFT(2), .MAX_SPEED(64), .TIMEOUT_CYCLES(100), .HOLD_CYCLES(50)
    ) dut_b (
        .clk(clk), .rstn(rstn), .rx_valid(b_valid), .rx_data(b_data), .rx_err(b_err),
        .vx(b_vx), .vy(b_vy), .dx(b_dx), .dy(b_dy), .mousepush(b_mp), .right_btn(b_rb),
        .mouseReady(b_mr), .pkt_err(b_pe)
    );

    typedef struct {
        logic [9:0] vx;
        logic [9:0] vy;
        logic       dx;
        logic       dy;
        logic       lb;
        logic       rb;
        int         cyc;
        string      name;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int perr_a = 0;
    int perr_b = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic check_pkt(input string dut, input exp_t e, input logic [9:0] vx, input logic [9:0] vy,
                             input logic dx, input logic dy, input logic lb, input logic rb, input int c);
        checks++;
        if ({vx, vy, dx, dy, lb, rb} !== {e.vx, e.vy, e.dx, e.dy, e.lb, e.rb} || c != e.cyc) begin
            errors++;
            $display("FAIL %s %s: got vx=%0d vy=%0d dx=%0b dy=%0b lb=%0b rb=%0b cyc=%0d, required vx=%0d vy=%0d dx=%0b dy=%0b lb=%0b rb=%0b cyc=%0d",
                     dut, e.name, vx, vy, dx, dy, lb, rb, c, e.vx, e.vy, e.dx, e.dy, e.lb, e.rb, e.cyc);
        end
    endtask

    // Monitor A: count error pulses, compare every decoded packet against the queue
    always @(negedge clk) begin
        if (a_pe) perr_a++;
        if (a_mr) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_ready: got mouseReady at cycle %0d, required none", cyc);
            end else begin
                ea = qa.pop_front();
                check_pkt("a", ea, a_vx, a_vy, a_dx, a_dy, a_mp, a_rb, cyc);
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (b_pe) perr_b++;
        if (b_mr) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_ready: got mouseReady at cycle %0d, required none", cyc);
            end else begin
                eb = qb.pop_front();
                check_pkt("b", eb, b_vx, b_vy, b_dx, b_dy, b_mp, b_rb, cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int sel, input logic v, input logic er, input logic [7:0] d);
        if (sel == 0) begin a_valid = v; a_err = er; a_data = d; end
        else          begin b_valid = v; b_err = er; b_data = d; end
    endtask

    task automatic send(input int sel, input logic [7:0] d);
        @(negedge clk); drive(sel, 1'b1, 1'b0, d);
        @(negedge clk); drive(sel, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_err(input int sel, input logic with_valid, input logic [7:0] d);
        @(negedge clk); drive(sel, with_valid, 1'b1, d);
        @(negedge clk); drive(sel, 1'b0, 1'b0, 8'h00);
    endtask

    // Final byte of a packet: expected decode due one cycle after it is sampled
    task automatic last(input int sel, input logic [7:0] d, input int vx, input int vy,
                        input logic dx, input logic dy, input logic lb, input logic rb, input string name);
        exp_t e;
        e.vx = 10'(vx); e.vy = 10'(vy); e.dx = dx; e.dy = dy; e.lb = lb; e.rb = rb; e.name = name;
        @(negedge clk);
        drive(sel, 1'b1, 1'b0, d);
        e.cyc = cyc + 1;
        if (sel == 0) qa.push_back(e); else qb.push_back(e);
        @(negedge clk); drive(sel, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic pkt(input int sel, input logic [7:0] h, input logic [7:0] x, input logic [7:0] y,
                       input int vx, input int vy, input logic dx, input logic dy,
                       input logic lb, input logic rb, input string name);
        send(sel, h);
        send(sel, x);
        last(sel, y, vx, vy, dx, dy, lb, rb, name);
    endtask

    initial begin
        rstn = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00);
        idle(3);
        check("a_reset_outputs", 32'({a_vx, a_vy, a_dx, a_dy, a_mp, a_rb, a_mr, a_pe}), 32'd0);
        check("b_reset_outputs", 32'({b_vx, b_vy, b_dx, b_dy, b_mp, b_rb, b_mr, b_pe}), 32'd0);
        rstn = 1'b1;

        // Unsynced: ACK and BAT ignored silently, a bad header flags an error
        send(0, 8'hFA); send(0, 8'hAA); idle(2);
        check("a_ack_bat_silent", 32'(perr_a), 32'd0);
        send(0, 8'h00); idle(2);
        check("a_bad_header_unsynced", 32'(perr_a), 32'd1);
        pkt(0, 8'h08, 8'h03, 8'h00,  3,  0, 1'b0, 1'b0, 1'b0, 1'b0, "first_packet");

        // Main decode patterns
        pkt(0, 8'h09, 8'h05, 8'h00,  5,  0, 1'b0, 1'b0, 1'b1, 1'b0, "plus5_lbtn");
        pkt(0, 8'h38, 8'hFB, 8'hF0,  5, 16, 1'b1, 1'b0, 1'b0, 1'b0, "neg_x_neg_y");
        pkt(0, 8'h08, 8'h01, 8'h02,  1,  2, 1'b0, 1'b1, 1'b0, 1'b0, "small_pos");
        pkt(0, 8'h48, 8'h10, 8'h00, 64,  0, 1'b0, 1'b0, 1'b0, 1'b0, "x_overflow");
        pkt(0, 8'h18, 8'h80, 8'h00, 64,  0, 1'b1, 1'b0, 1'b0, 1'b0, "x_minus128");
        pkt(0, 8'h18, 8'h00, 8'h00, 64,  0, 1'b1, 1'b0, 1'b0, 1'b0, "x_minus256");
        pkt(0, 8'h0A, 8'h3F, 8'h00, 63,  0, 1'b0, 1'b0, 1'b0, 1'b1, "x63_rbtn");
        pkt(0, 8'h08, 8'h40, 8'h41, 64, 64, 1'b0, 1'b1, 1'b0, 1'b0, "clamp_edge");
        pkt(0, 8'h88, 8'h00, 8'h00,  0, 64, 1'b0, 1'b1, 1'b0, 1'b0, "y_overflow");
        pkt(0, 8'h28, 8'h00, 8'h00,  0, 64, 1'b0, 1'b0, 1'b0, 1'b0, "y_minus256");

        // Inter-byte timeout drops the partial packet without an error
        send(0, 8'h08); send(0, 8'h07); idle(101);
        pkt(0, 8'h08, 8'h01, 8'h02,  1,  2, 1'b0, 1'b1, 1'b0, 1'b0, "after_timeout");
        idle(2);
        check("a_timeout_no_err", 32'(perr_a), 32'd1);
        send(0, 8'h08); send(0, 8'h07); idle(90);
        last(0, 8'h02, 7, 2, 1'b0, 1'b1, 1'b0, 1'b0, "just_before_timeout");

        // Receiver errors: mid-packet flags and resyncs, in B0 is silent
        send(0, 8'h08); send_err(0, 1'b0, 8'h00); idle(2);
        check("a_rxerr_after_header", 32'(perr_a), 32'd2);
        pkt(0, 8'h08, 8'h04, 8'h00,  4,  0, 1'b0, 1'b0, 1'b0, 1'b0, "after_rxerr");
        send(0, 8'h08); send(0, 8'h06); send_err(0, 1'b1, 8'h00); idle(2);
        check("a_rxerr_beats_valid", 32'(perr_a), 32'd3);
        pkt(0, 8'h08, 8'h06, 8'h00,  6,  0, 1'b0, 1'b0, 1'b0, 1'b0, "after_rxerr_valid");
        send_err(0, 1'b0, 8'h00); idle(2);
        check("a_rxerr_in_b0", 32'(perr_a), 32'd3);
        send(0, 8'h00); idle(2);
        check("a_bad_header_synced", 32'(perr_a), 32'd4);

        // Hold-off: velocity clears after the idle window, button level stays
        pkt(0, 8'h19, 8'hFB, 8'h00,  5,  0, 1'b1, 1'b0, 1'b1, 1'b0, "hold_src");
        idle(40);
        check("a_hold_not_yet", 32'({a_vx, a_dx, a_mp}), 32'({10'd5, 1'b1, 1'b1}));
        idle(15);
        check("a_hold_cleared", 32'({a_vx, a_vy, a_dx, a_dy, a_mp, a_rb}), 32'({10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0}));

        // Reset mid-packet discards the partial packet
        send(0, 8'h09); send(0, 8'h05);
        @(negedge clk); rstn = 1'b0;
        @(negedge clk);
        check("a_reset_mid_packet", 32'({a_vx, a_vy, a_dx, a_dy, a_mp, a_rb, a_mr, a_pe}), 32'd0);
        rstn = 1'b1;
        pkt(0, 8'h08, 8'h02, 8'h01,  2,  1, 1'b0, 1'b1, 1'b0, 1'b0, "after_reset");

        // SHIFT=2 instance
        pkt(1, 8'h08, 8'h14, 8'h00,  5,  0, 1'b0, 1'b0, 1'b0, 1'b0, "shift_20");
        pkt(1, 8'h08, 8'hFF, 8'h00, 63,  0, 1'b0, 1'b0, 1'b0, 1'b0, "shift_255");
        pkt(1, 8'h18, 8'h00, 8'h00, 64,  0, 1'b1, 1'b0, 1'b0, 1'b0, "shift_minus256");
        pkt(1, 8'h08, 8'h03, 8'h00,  0,  0, 1'b0, 1'b0, 1'b0, 1'b0, "shift_to_zero");
        pkt(1, 8'h18, 8'hFD, 8'h00,  0,  0, 1'b0, 1'b0, 1'b0, 1'b0, "neg_shift_to_zero");
        pkt(1, 8'h48, 8'h01, 8'h00, 64,  0, 1'b0, 1'b0, 1'b0, 1'b0, "shift_overflow");
        pkt(1, 8'h09, 8'h00, 8'h0B,  0,  2, 1'b0, 1'b1, 1'b1, 1'b0, "shift_y11");
        idle(2);
        check("b_no_pkt_err", 32'(perr_b), 32'd0);

        idle(5);
        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
